shift_sequencer: RTL

//  Sequences one 32-bit load/shift register (SHIFT=1: shift left by 1; SHIFT=0: load DATA_IN every clock).

---
 rtl/shift_seq_pkg.sv | 22 ++
 rtl/shift_seq_cnt.sv | 38 +++
 rtl/shift_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: datapath width, count width,
// FSM state encoding and the count-saturation helper.
package shift_seq_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFTING = 2'd1,
      DONE     = 2'd2
   } state_e;

   // Shifting more than WIDTH times only ever yields zero, so clamp the request.
   function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] count);
      if (count > CNT_W'(WIDTH)) begin
         return CNT_W'(WIDTH);
      end
      return count;
   endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter holding the number of shift cycles still to issue.
// The load value is clamped to WIDTH; decrementing stops at zero.
module shift_seq_cnt
   import shift_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             is_one_o,
   output logic             is_zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = sat_count(load_val_i);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign is_one_o  = (cnt_q == CNT_W'(1));
   assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Drives an external load/shift register: loads a command word, issues the
// requested number of left shifts, then presents the register value as a result.
module shift_sequencer
   import shift_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [WIDTH-1:0] cmd_data_i,
   input  logic [CNT_W-1:0] cmd_count_i,
   input  logic             abort_i,
   output logic             reg_shift_o,
   output logic [WIDTH-1:0] reg_din_o,
   input  logic [WIDTH-1:0] reg_dout_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [WIDTH-1:0] res_data_o
);

   state_e state_q;
   logic   cmd_ready_q;
   logic   res_valid_q;
   logic   shift_q;
   logic   accept;
   logic   cnt_is_one;
   logic   cnt_is_zero;

   // cmd_ready_q is only ever high in IDLE, so it doubles as the accept qualifier.
   assign accept = cmd_valid_i & cmd_ready_q;

   shift_seq_cnt u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (accept),
      .load_val_i (cmd_count_i),
      .dec_i      (shift_q),
      .is_one_o   (cnt_is_one),
      .is_zero_o  (cnt_is_zero)
   );

   // Handshake outputs are registered alongside the state so they stay low
   // through reset and rise on the first edge after reset is released.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         res_valid_q <= 1'b0;
         shift_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cmd_ready_q <= 1'b0;
                  if (cmd_count_i == '0) begin
                     state_q     <= DONE;
                     res_valid_q <= 1'b1;
                  end else begin
                     state_q <= SHIFTING;
                     shift_q <= 1'b1;
                  end
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            SHIFTING: begin
               if (abort_i || cnt_is_one || cnt_is_zero) begin
                  state_q     <= DONE;
                  shift_q     <= 1'b0;
                  res_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (res_ready_i) begin
                  state_q     <= IDLE;
                  res_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b0;
               res_valid_q <= 1'b0;
               shift_q     <= 1'b0;
            end
         endcase
      end
   end

   // An abort suppresses the shift on the edge that leaves SHIFTING.
   assign reg_shift_o = shift_q & ~abort_i;
   assign reg_din_o   = accept ? cmd_data_i : reg_dout_i;
   assign cmd_ready_o = cmd_ready_q;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = reg_dout_i;

endmodule
